// File: rtl/data_mem_bridge_if.sv
// Request/acknowledge bus between the data-memory bridge (master) and a multi-cycle memory (slave).
interface data_mem_bridge_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (output bus_req, bus_we, bus_addr, bus_wdata, input bus_rdata, bus_ack);
  modport slave  (input bus_req, bus_we, bus_addr, bus_wdata, output bus_rdata, bus_ack);
endinterface

// File: rtl/data_mem_bridge.sv
// MEM-stage to multi-cycle data memory bridge: turns single-cycle load/store requests into
// req/ack bus transactions, stalls the pipeline meanwhile and flags misalignment and timeouts.
module data_mem_bridge #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_ren,
  input  logic              cpu_wen,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_dout,
  input  logic              cpu_adv,
  output logic [31:0]       cpu_din,
  output logic              mem_stall,
  data_mem_bridge_if.master bus,
  input  logic              err_clr,
  output logic              err_misalign,
  output logic              err_timeout
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t           state, state_nxt;
  logic             access, aligned, start, misaligned, expired;
  logic             we_q;
  logic [31:0]      addr_q, wdata_q, hold;
  logic [CNT_W-1:0] cnt;

  assign access     = cpu_ren | cpu_wen;
  assign aligned    = (cpu_addr[1:0] == 2'b00);
  assign start      = (state == IDLE) && access && aligned;
  assign misaligned = (state == IDLE) && access && !aligned;
  assign expired    = (state == REQ) && !bus.bus_ack && (cnt == CNT_W'(TIMEOUT - 1));

  assign bus.bus_req   = (state == REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_stall = 1'b0;
    cpu_din   = hold;
    case (state)
      IDLE: begin
        // Detection is combinational, so reset must mask the stall explicitly.
        if (start) begin
          mem_stall = ~rst;
          state_nxt = REQ;
        end else if (misaligned) begin
          cpu_din = '0;
        end
      end
      REQ: begin
        mem_stall = 1'b1;
        if (bus.bus_ack || expired) state_nxt = DONE;
      end
      DONE: begin
        if (cpu_adv) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      hold         <= '0;
      cnt          <= '0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      if (start) begin
        addr_q  <= cpu_addr;
        we_q    <= cpu_wen;
        wdata_q <= cpu_dout;
        cnt     <= '0;
      end
      if (state == REQ) begin
        if (bus.bus_ack) begin
          if (!we_q) hold <= bus.bus_rdata;
        end else if (expired) begin
          hold <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      // A flag being set in the same cycle as err_clr stays set.
      if (misaligned)   err_misalign <= 1'b1;
      else if (err_clr) err_misalign <= 1'b0;
      if (expired)      err_timeout  <= 1'b1;
      else if (err_clr) err_timeout  <= 1'b0;
    end
  end
endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
- Sits between the pipeline's MEM stage and a multi-cycle data memory with a req/ack handshake.
- Converts the single-cycle mem_ren/mem_wen/mem_addr/mem_dout/mem_din view into bus transactions.
- Raises mem_stall to the pipeline controller until each access completes.
- Holds read data stable until the pipeline advances the MEM-stage instruction.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 16: max cycles in REQ waiting for bus_ack before abort (≥1).
- CNT_W, 5: width of the timeout counter; must hold TIMEOUT.

Ports:
- clk  input  1  main clock
- rst  input  1  reset; asynchronous, active-high
- cpu_ren  input  1  MEM-stage read enable
- cpu_wen  input  1  MEM-stage write enable
- cpu_addr  input  32  MEM-stage byte address
- cpu_dout  input  32  store data from pipeline
- cpu_adv  input  1  pipeline latches the MEM-stage instruction at this edge (mem_en of next stage)
- cpu_din  output  32  load data to pipeline
- mem_stall  output  1  pipeline must hold IF..MEM
- bus_req  output  1  transaction request
- bus_we  output  1  1 = write
- bus_addr  output  32  word-aligned address
- bus_wdata  output  32  write data
- bus_rdata  input  32  read data, valid with bus_ack
- bus_ack  input  1  transaction complete (1-cycle pulse)
- err_clr  input  1  clears sticky error flags
- err_misalign  output  1  sticky: misaligned access seen
- err_timeout  output  1  sticky: bus timeout seen

Behaviour:
- Reset (async, any state): state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, hold=0, cnt=0, err flags=0, mem_stall=0, cpu_din=0.
- Reset mid-REQ drops bus_req in the same cycle. A late bus_ack after reset is ignored.
- access = cpu_ren|cpu_wen; is_wr = cpu_wen. If both enables are set, the access is a write.
- States: IDLE, REQ, DONE.
- IDLE, aligned access (cpu_addr[1:0]==0):
  - mem_stall=1 combinationally.
  - Next state REQ.
  - Register bus_addr=cpu_addr, bus_we=is_wr, bus_wdata=cpu_dout; cnt=0.
- IDLE, misaligned access:
  - No bus transaction; mem_stall=0; cpu_din=0.
  - err_misalign set next edge; stay IDLE.
- IDLE, no access: mem_stall=0, cpu_din=hold.
- REQ:
  - bus_req=1, mem_stall=1.
  - On bus_ack: hold=bus_rdata for reads (unchanged for writes), go DONE.
  - Else cnt++.
  - cnt==TIMEOUT-1 without ack: hold=0, err_timeout set, go DONE.
  - bus_req and the bus_* registers stay constant throughout REQ.
- DONE:
  - bus_req=0, mem_stall=0, cpu_din=hold.
  - If cpu_adv, go IDLE; otherwise stay DONE (controller stalled for another reason). No re-issue.
- Latency: minimum 2 stall cycles (detect cycle + 1 REQ cycle with immediate ack). Total stall = 1 + cycles in REQ.
- bus_ack while not in REQ is ignored; state and hold are unchanged.
- err_clr: clears both flags at the next edge. If a set and err_clr coincide, the set wins.
- Back-to-back accesses: DONE->IDLE on cpu_adv. The next access is detected in IDLE the following cycle, so there is no bubble beyond the detect cycle.
- cpu_din is stable from entry to DONE until cpu_adv is accepted.

Test Plan:
- Read, ack 1 cycle after bus_req (bus_rdata=32'h1234_5678, addr=32'h40) → mem_stall high 2 cycles; bus_addr=32'h40, bus_we=0; DONE with cpu_din=32'h1234_5678, mem_stall=0.
- Write addr=32'h44, cpu_dout=32'hCAFE_F00D, ack after 4 cycles → bus_we=1, bus_wdata constant for all 4 REQ cycles; stall 5 cycles; hold unchanged.
- Read, no ack, TIMEOUT=16 → bus_req high exactly 16 cycles then drops; err_timeout=1; cpu_din=0; mem_stall low. Then err_clr → err_timeout=0.
- Read addr=32'h42 → no bus_req; mem_stall stays 0; err_misalign=1 next cycle; cpu_din=0.
- DONE with cpu_adv=0 for 3 cycles → cpu_din holds value; no new bus_req. cpu_adv=1 followed by a new read → new transaction starts.
- rst asserted in 2nd REQ cycle → bus_req=0 immediately; a later ack is ignored; state IDLE, err flags 0.
